enc_tx_queue: RTL

- Transmit-side packet queue directly upstream of the PPM Encoder.
- Buffers N_PKT-bit words from a producer (switches/host logic) in a FIFO and launches them one at a time into the Encoder via its start/avail handshake.
- Holds enc_data stable for the full transmission and enforces a programmable idle gap between packets.
- Retries a launch the Encoder fails to acknowledge.

---
 rtl/enc_tx_queue.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/enc_tx_queue.sv
// enc_tx_queue: transmit packet queue feeding the PPM Encoder.
// Words from a producer are buffered in a FIFO. They are launched one at a time into the Encoder
// through its start/avail handshake. The launched word is held on enc_data for the whole
// transmission, and a programmable idle gap follows each packet. A launch the Encoder does not
// acknowledge within ACK_TO cycles is retried with the same word.
//
// Parameters: N_PKT (word width), DEPTH (FIFO entries, power of two >= 2),
//             GAP_CT (idle cycles after done, 0 allowed), ACK_TO (ack wait cycles, >= 1)
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   wr_data/valid     enqueue word and request
//   wr_ready          FIFO not full (from registered count)
//   enc_data          word presented to the Encoder (registered)
//   enc_start         one-cycle launch pulse (registered)
//   enc_avail         Encoder idle/ready
//   count             FIFO occupancy
//   overflow          sticky: push attempted while full
//   busy              transmit FSM not idle
// Optional (macro ENC_TXQ_STATS_EN): sent_count [15:0] wrapping, retry_count [7:0] saturating.
module enc_tx_queue #(
  parameter int unsigned N_PKT  = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned GAP_CT = 16,
  parameter int unsigned ACK_TO = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PKT-1:0]             wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic [N_PKT-1:0]             enc_data,
  output logic                         enc_start,
  input  logic                         enc_avail,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         busy
`ifdef ENC_TXQ_STATS_EN
  ,
  output logic [15:0]                  sent_count,
  output logic [7:0]                   retry_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned AW = $clog2(ACK_TO + 1);
  localparam int unsigned GW = (GAP_CT > 0) ? $clog2(GAP_CT + 1) : 1;

  localparam logic [CW-1:0] Full    = CW'(DEPTH);
  // Timer value on the cycle whose increment would reach ACK_TO / GAP_CT.
  localparam logic [AW-1:0] AckLast = AW'(ACK_TO - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP_CT > 0) ? GAP_CT - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitAck,
    StWaitDone,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [N_PKT-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [AW-1:0]     ack_q, ack_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [N_PKT-1:0]  enc_data_q;
  logic              enc_start_q;
  logic              overflow_q;
  logic              push, pop, retry, sent;

  assign wr_ready  = (count_q != Full);
  assign push      = wr_valid & wr_ready;
  assign enc_data  = enc_data_q;
  assign enc_start = enc_start_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    retry   = 1'b0;
    sent    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && enc_avail) begin
          pop     = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        ack_d   = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (!enc_avail) begin
          state_d = StWaitDone;
        end else if (ack_q == AckLast) begin
          retry   = 1'b1;
          state_d = StLaunch;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (enc_avail) begin
          sent = 1'b1;
          if (GAP_CT == 0) begin
            state_d = StIdle;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ack_q       <= '0;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enc_data_q  <= '0;
      enc_start_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      gap_q       <= gap_d;
      // Registered copy of "in LAUNCH"; LAUNCH always exits after one cycle.
      enc_start_q <= (state_d == StLaunch);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        enc_data_q <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (wr_valid && !wr_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef ENC_TXQ_STATS_EN
  logic [15:0] sent_q;
  logic [7:0]  retry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q  <= '0;
      retry_q <= '0;
    end else begin
      if (sent) begin
        sent_q <= sent_q + 16'd1;
      end
      if (retry && (retry_q != 8'hFF)) begin
        retry_q <= retry_q + 8'd1;
      end
    end
  end

  assign sent_count  = sent_q;
  assign retry_count = retry_q;
`else
  // Without the statistics option the completion and retry strobes have no consumer.
  logic unused_stats;
  assign unused_stats = sent ^ retry;
`endif

endmodule
